// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared Hack RAM8 constants and reader state encoding
package hack_pkg;

  localparam int HACK_WIDTH  = 16;
  localparam int HACK_DEPTH  = 8;
  localparam int HACK_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/ram8.sv
// rtl/ram8.sv - eight-word storage, synchronous write, asynchronous read
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH,
  parameter int DEPTH = HACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [HACK_ADDR_W-1:0] address,
  input  logic [HACK_ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]       out
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load) begin
      mem[address] <= in;
    end
  end

  // Separate read index lets the reader fetch while the host writes elsewhere.
  assign out = mem[raddr];

endmodule

// File: rtl/ram8_reader.sv
// rtl/ram8_reader.sv - RAM8 with a handshaked full-readback stream
module ram8_reader
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH,
  parameter int DEPTH = HACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [HACK_ADDR_W-1:0] address,
  input  logic                   start,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  state_t                 state;
  logic [HACK_ADDR_W-1:0] ptr;
  logic [HACK_ADDR_W-1:0] fetch_idx;
  logic [WIDTH-1:0]       rdata;
  logic [WIDTH-1:0]       fetch_word;
  logic                   last;

  ram8 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram8 (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .raddr   (fetch_idx),
    .out     (rdata)
  );

  // Word 0 on start, the next word on a handshake; a same-cycle write to it wins.
  always_comb begin
    fetch_idx  = (state == PRESENT) ? ptr + 3'd1 : '0;
    fetch_word = (load && (address == fetch_idx)) ? in : rdata;
    last       = (ptr == HACK_ADDR_W'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= PRESENT;
            ptr       <= '0;
            out       <= fetch_word;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              ptr <= ptr + 3'd1;
              out <= fetch_word;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_reader.sv
// tb/tb_ram8_reader.sv - scoreboard bench for ram8_reader
module tb_ram8_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        start;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  ram8_reader dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .load      (load),
    .address   (address),
    .start     (start),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          hs_count = 0;
  int          done_pulses = 0;
  int          cyc = 0;
  int          last_hs_cyc = -10;
  logic [15:0] exp_q [$];
  logic [15:0] model [8];
  logic        held = 1'b0;
  logic [15:0] held_val = '0;
  logic        prev_done = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops an expected word on every handshake, watches stalls and done.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      held      = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (held && out_valid) chk("stall_hold", out, held_val);
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          chk("stream_word", out, exp_q.pop_front());
        end
        hs_count++;
        last_hs_cyc = cyc;
      end else if (out_valid) begin
        held     = 1'b1;
        held_val = out;
      end
      if (done) begin
        done_pulses++;
        chk("done_width", prev_done, 0);
        chk("done_after_last", cyc - last_hs_cyc, 1);
        chk("busy_at_done", busy, 1);
        chk("valid_at_done", out_valid, 0);
      end
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    load    = 1'b1;
    address = 3'(a);
    in      = 16'(d);
    tick();
    load      = 1'b0;
    model[a]  = 16'(d);
  endtask

  task automatic push_model();
    for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
  endtask

  task automatic finish_stream(input int hs0, input int dn0, input int nhs, input int ndn);
    int ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("stream_timeout", ok, 1);
    #1;
    chk("handshake_count", hs_count - hs0, nhs);
    chk("done_count", done_pulses - dn0, ndn);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_valid", out_valid, 0);
    tick();
  endtask

  task automatic stream_ready();
    int hs0, dn0;
    hs0 = hs_count;
    dn0 = done_pulses;
    push_model();
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid", out_valid, 1);
    chk("start_busy", busy, 1);
    finish_stream(hs0, dn0, 8, 1);
  endtask

  initial begin
    int hs0, dn0, ok;
    reset = 1'b1; in = '0; load = 1'b0; address = '0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    tick(); tick();
    chk("reset_out", out, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) write_word(i, 1000 + i);

    // Continuous ready: 1000..1007 back to back.
    stream_ready();

    // Backpressure: ready pattern 1,0,0 repeating.
    hs0 = hs_count; dn0 = done_pulses;
    push_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      out_ready = (k % 3 == 0);
      tick();
    end
    finish_stream(hs0, dn0, 8, 1);

    // start held through the stream and done cycle, accepted on first idle cycle.
    hs0 = hs_count; dn0 = done_pulses;
    push_model();
    start = 1'b1; out_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    chk("done_seen", ok, 1);
    push_model();
    tick();
    chk("done_start_ignored_busy", busy, 0);
    chk("done_start_ignored_valid", out_valid, 0);
    tick();
    start = 1'b0;
    chk("restart_valid", out_valid, 1);
    chk("restart_word0", out, model[0]);
    finish_stream(hs0, dn0, 16, 2);

    // Write-through on fetch, stalled write to the presented word.
    hs0 = hs_count; dn0 = done_pulses;
    exp_q.push_back(model[0]); exp_q.push_back(model[1]); exp_q.push_back(model[2]);
    exp_q.push_back(16'd2222);
    for (int i = 4; i < 8; i++) exp_q.push_back(model[i]);
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    write_word(2, 5555);
    chk("stalled_write_hold", out, 1002);
    out_ready = 1'b1;
    write_word(3, 2222);
    chk("write_through", out, 2222);
    finish_stream(hs0, dn0, 8, 1);

    // Reset after 4 handshakes, with load and start in the same cycle.
    hs0 = hs_count; dn0 = done_pulses;
    push_model();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1; load = 1'b1; address = 3'd5; in = 16'd777; start = 1'b1;
    tick();
    reset = 1'b0; load = 1'b0; start = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_handshakes", hs_count - hs0, 4);
    chk("abort_remaining", exp_q.size(), 4);
    exp_q.delete();
    for (int i = 0; i < 8; i++) model[i] = '0;
    repeat (3) tick();
    chk("abort_no_done", done_pulses - dn0, 0);

    // Memory cleared by reset: stream reads all zeros.
    stream_ready();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end

endmodule
